serial_bridge: RTL and testbench

SERIAL_BRIDGE -- requirements
Module: serial_bridge

---
 rtl/serial_bridge.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_bridge.sv
// serial_bridge: CPU byte interface <-> 8N1 UART.
// A TX FIFO feeds the transmit FSM; the receive FSM feeds an RX FIFO the CPU
// pops. Both paths run concurrently and share only the clock and reset.
module serial_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_data_in,
  input  logic       cpu_wren_in,
  input  logic       cpu_rden_in,
  output logic [7:0] cpu_data_out,
  output logic       cpu_valid_out,
  output logic       cpu_ready_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       rx_overrun_out
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // ---------------- FIFO storage / occupancy ----------------
  logic [FIFO_DEPTH-1:0][7:0] tx_mem_q, rx_mem_q;
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0] tx_head;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));

  assign cpu_ready_out = !tx_full;
  assign cpu_valid_out = !rx_empty;
  assign cpu_data_out  = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
  assign tx_head       = tx_mem_q[tx_rptr_q];

  assign tx_push = cpu_wren_in && !tx_full;
  assign rx_pop  = cpu_rden_in && !rx_empty;

  // ---------------- TX FSM ----------------
  tx_state_e      tx_state_q;
  logic [BCW-1:0] tx_clk_q;
  logic [2:0]     tx_bit_q;
  logic [7:0]     tx_sh_q;
  logic           tx_q;
  logic           tx_bit_end;

  assign tx_bit_end  = (tx_clk_q == BCW'(CLKS_PER_BIT - 1));
  // The FSM takes the head byte when leaving IDLE or when chaining frames.
  assign tx_pop      = !tx_empty &&
                       ((tx_state_q == TX_IDLE) ||
                        (tx_state_q == TX_STOP && tx_bit_end));
  assign uart_tx_out = tx_q;

  // Transmit sequencer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_clk_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (!tx_empty) begin
            tx_state_q <= TX_START;
            tx_sh_q    <= tx_head;
            tx_clk_q   <= '0;
            tx_q       <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_clk_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_sh_q[0];
          end else tx_clk_q <= tx_clk_q + 1'b1;
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_clk_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
              tx_q     <= tx_sh_q[1];
            end
          end else tx_clk_q <= tx_clk_q + 1'b1;
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_clk_q <= '0;
            if (!tx_empty) begin
              tx_state_q <= TX_START;
              tx_sh_q    <= tx_head;
              tx_q       <= 1'b0;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else tx_clk_q <= tx_clk_q + 1'b1;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX synchronizer + FSM ----------------
  logic [1:0]     rx_sync_q;
  logic           rxs;
  rx_state_e      rx_state_q;
  logic [BCW-1:0] rx_clk_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_sh_q;
  logic           rx_overrun_q;
  logic           rx_half_end, rx_bit_end, rx_stop_smp;

  assign rxs         = rx_sync_q[1];
  assign rx_half_end = (rx_clk_q == BCW'(CLKS_PER_BIT / 2 - 1));
  assign rx_bit_end  = (rx_clk_q == BCW'(CLKS_PER_BIT - 1));
  assign rx_stop_smp = (rx_state_q == RX_STOP) && rx_bit_end;
  // A full FIFO still accepts the byte if the CPU frees a slot this cycle.
  assign rx_push     = rx_stop_smp && rxs && (!rx_full || rx_pop);
  assign rx_overrun_out = rx_overrun_q;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_sync_q <= 2'b11;
    else       rx_sync_q <= {rx_sync_q[0], uart_rx_in};
  end

  // Receive sequencer: mid-bit sampling, false-start and framing rejection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      rx_clk_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      if (rx_stop_smp && rxs && rx_full && !rx_pop) rx_overrun_q <= 1'b1;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state_q <= RX_START;
            rx_clk_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_half_end) begin
            rx_clk_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxs ? RX_IDLE : RX_DATA;
          end else rx_clk_q <= rx_clk_q + 1'b1;
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_clk_q <= '0;
            rx_sh_q  <= {rxs, rx_sh_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 1'b1;
          end else rx_clk_q <= rx_clk_q + 1'b1;
        end
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_clk_q   <= '0;
            rx_state_q <= RX_IDLE;
          end else rx_clk_q <= rx_clk_q + 1'b1;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Next-state for both FIFO pointer/count sets; pointers wrap naturally.
  always_comb begin
    tx_wptr_d = tx_wptr_q + AW'(tx_push);
    tx_rptr_d = tx_rptr_q + AW'(tx_pop);
    tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wptr_d = rx_wptr_q + AW'(rx_push);
    rx_rptr_d = rx_rptr_q + AW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  // FIFO pointer/count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO data arrays; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= cpu_data_in;
    if (rx_push) rx_mem_q[rx_wptr_q] <= rx_sh_q;
  end

endmodule

// File: tb/tb_serial_bridge.sv
// Directed bench for serial_bridge at 4 clocks/bit, 4-entry FIFOs.
module tb_serial_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_data_in;
  logic       cpu_wren_in, cpu_rden_in;
  logic [7:0] cpu_data_out;
  logic       cpu_valid_out, cpu_ready_out;
  logic       uart_rx_in, uart_tx_out, rx_overrun_out;

  int tests = 0;
  int fails = 0;

  serial_bridge #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_data_in(cpu_data_in), .cpu_wren_in(cpu_wren_in), .cpu_rden_in(cpu_rden_in),
    .cpu_data_out(cpu_data_out), .cpu_valid_out(cpu_valid_out), .cpu_ready_out(cpu_ready_out),
    .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out), .rx_overrun_out(rx_overrun_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_stop;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tx_write(input logic [7:0] b);
    @(negedge clk); cpu_data_in = b; cpu_wren_in = 1'b1;
    @(negedge clk); cpu_wren_in = 1'b0;
  endtask

  // Expects a frame whose start bit appears at the next negedge.
  task automatic check_frame(input logic [7:0] b);
    logic e;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 4)       e = 1'b0;
      else if (k < 36) e = b[(k - 4) / 4];
      else             e = 1'b1;
      chk($sformatf("tx_bit %02h k=%0d", b, k), uart_tx_out, e);
    end
  endtask

  // Drives one 8N1 frame; optionally pulses rden on the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); uart_rx_in = f[j];
      end
    @(negedge clk); uart_rx_in = 1'b1; cpu_rden_in = pop;
    @(negedge clk); cpu_rden_in = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_chk(input logic [7:0] e);
    chk($sformatf("pop_valid %02h", e), cpu_valid_out, 1'b1);
    chk($sformatf("pop_data %02h", e), cpu_data_out, e);
    @(negedge clk); cpu_rden_in = 1'b1;
    @(negedge clk); cpu_rden_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] fill [6];
    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 8'h3C};
    vecs[1] = '{8'h00, 8'hA7, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b1, 8'h00};
    vecs[3] = '{8'h5A, 8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[4] = '{8'h81, 8'h81, 1'b1, 1'b1, 8'h81};
    fill = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};

    reset = 1'b1; cpu_data_in = 8'h00; cpu_wren_in = 1'b0; cpu_rden_in = 1'b0;
    uart_rx_in = 1'b1;
    #2;
    chk("rst_tx", uart_tx_out, 1'b1);
    chk("rst_ready", cpu_ready_out, 1'b1);
    chk("rst_valid", cpu_valid_out, 1'b0);
    chk("rst_data", cpu_data_out, 8'h00);
    chk("rst_overrun", rx_overrun_out, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table: one TX frame and one RX frame in flight at the same time.
    for (int v = 0; v < 5; v++) begin
      fork
        begin
          tx_write(vecs[v].tx_byte);
          chk($sformatf("v%0d_ready", v), cpu_ready_out, 1'b1);
          check_frame(vecs[v].tx_byte);
        end
        send_frame(vecs[v].rx_byte, vecs[v].rx_stop, 1'b0);
      join
      chk($sformatf("v%0d_tx_idle", v), uart_tx_out, 1'b1);
      chk($sformatf("v%0d_valid", v), cpu_valid_out, vecs[v].exp_valid);
      chk($sformatf("v%0d_data", v), cpu_data_out, vecs[v].exp_data);
      chk($sformatf("v%0d_overrun", v), rx_overrun_out, 1'b0);
      if (vecs[v].exp_valid) begin
        @(negedge clk); cpu_rden_in = 1'b1;
        @(negedge clk); cpu_rden_in = 1'b0;
        chk($sformatf("v%0d_valid_after_pop", v), cpu_valid_out, 1'b0);
        chk($sformatf("v%0d_data_after_pop", v), cpu_data_out, 8'h00);
      end
    end

    // TX fill: six writes on consecutive cycles, the sixth is dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (i == 4) chk("fill_ready_before_b5", cpu_ready_out, 1'b1);
          if (i == 5) chk("fill_ready_after_b5", cpu_ready_out, 1'b0);
          cpu_data_in = fill[i]; cpu_wren_in = 1'b1;
        end
        @(negedge clk); cpu_wren_in = 1'b0;
        chk("fill_ready_after_b6", cpu_ready_out, 1'b0);
      end
      begin
        @(negedge clk);
        @(negedge clk);
        for (int f = 0; f < 5; f++) check_frame(fill[f]);
      end
    join
    chk("fill_ready_drained", cpu_ready_out, 1'b1);
    repeat (8) @(negedge clk);
    chk("fill_b6_dropped_idle", uart_tx_out, 1'b1);

    // RX glitch: one-cycle low pulse must not produce a byte.
    @(negedge clk); uart_rx_in = 1'b0;
    @(negedge clk); uart_rx_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_valid", cpu_valid_out, 1'b0);
    send_frame(8'h6E, 1'b1, 1'b0);
    pop_chk(8'h6E);
    chk("glitch_empty", cpu_valid_out, 1'b0);

    // Empty FIFO with push and pop together: push only.
    send_frame(8'h11, 1'b1, 1'b1);
    chk("empty_pushpop_valid", cpu_valid_out, 1'b1);
    chk("empty_pushpop_data", cpu_data_out, 8'h11);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h13, 1'b1, 1'b0);
    send_frame(8'h14, 1'b1, 1'b0);
    // Full FIFO with push and pop together: both taken, no overrun.
    send_frame(8'h15, 1'b1, 1'b1);
    chk("full_pushpop_overrun", rx_overrun_out, 1'b0);
    pop_chk(8'h12);
    pop_chk(8'h13);
    pop_chk(8'h14);
    pop_chk(8'h15);
    chk("full_pushpop_empty", cpu_valid_out, 1'b0);

    // Overrun: five frames, no reads.
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      if (i == 4) chk("ovr_before", rx_overrun_out, 1'b0);
    end
    chk("ovr_set", rx_overrun_out, 1'b1);
    chk("ovr_head", cpu_data_out, 8'h01);
    for (int i = 1; i <= 4; i++) pop_chk(8'(i));
    chk("ovr_empty", cpu_valid_out, 1'b0);
    chk("ovr_sticky", rx_overrun_out, 1'b1);

    // Reset in the middle of a TX frame (DATA state), with a byte queued.
    tx_write(8'hC5);
    tx_write(8'h3A);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_tx", uart_tx_out, 1'b1);
    chk("midrst_ready", cpu_ready_out, 1'b1);
    chk("midrst_overrun", rx_overrun_out, 1'b0);
    chk("midrst_valid", cpu_valid_out, 1'b0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_idle k=%0d", k), uart_tx_out, 1'b1);
    end
    tx_write(8'h96);
    check_frame(8'h96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
